// File: rtl/picomips_pkg.sv
// Shared picoMIPS types: opcode and sequencer-state encodings plus default field widths.
package picomips_pkg;

  localparam int ADDR_WIDTH_DEF   = 6;
  localparam int OPCODE_WIDTH_DEF = 3;
  localparam int INSTR_WIDTH_DEF  = 16;

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_ALU  = 3'd1,
    OP_MUL  = 3'd2,
    OP_BEQ  = 3'd3,
    OP_BNE  = 3'd4,
    OP_JMP  = 3'd5,
    OP_WAIT = 3'd6,
    OP_HALT = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_EXEC   = 3'd1,
    S_MULW   = 3'd2,
    S_WAITHI = 3'd3,
    S_WAITLO = 3'd4,
    S_HALT   = 3'd5
  } seq_state_t;

  // Opcode sits in the top bits of the instruction word.
  function automatic logic [OPCODE_WIDTH_DEF-1:0] opcode_field(
      input logic [INSTR_WIDTH_DEF-1:0] instr_word);
    return instr_word[INSTR_WIDTH_DEF-1 -: OPCODE_WIDTH_DEF];
  endfunction

endpackage

// File: rtl/op_decode.sv
// Combinational opcode classifier; anything not recognised is treated as a NOP.
module op_decode
  import picomips_pkg::*;
#(
  parameter int OPCODE_WIDTH = OPCODE_WIDTH_DEF
) (
  input  logic [OPCODE_WIDTH-1:0] opcode,
  output logic                    is_nop,
  output logic                    is_alu,
  output logic                    is_mul,
  output logic                    is_beq,
  output logic                    is_bne,
  output logic                    is_jmp,
  output logic                    is_wait,
  output logic                    is_halt
);

  always_comb begin
    is_nop  = 1'b0;
    is_alu  = 1'b0;
    is_mul  = 1'b0;
    is_beq  = 1'b0;
    is_bne  = 1'b0;
    is_jmp  = 1'b0;
    is_wait = 1'b0;
    is_halt = 1'b0;
    case (opcode)
      OPCODE_WIDTH'(OP_ALU):  is_alu  = 1'b1;
      OPCODE_WIDTH'(OP_MUL):  is_mul  = 1'b1;
      OPCODE_WIDTH'(OP_BEQ):  is_beq  = 1'b1;
      OPCODE_WIDTH'(OP_BNE):  is_bne  = 1'b1;
      OPCODE_WIDTH'(OP_JMP):  is_jmp  = 1'b1;
      OPCODE_WIDTH'(OP_WAIT): is_wait = 1'b1;
      OPCODE_WIDTH'(OP_HALT): is_halt = 1'b1;
      default:                is_nop  = 1'b1;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// picoMIPS multi-cycle control: fetch/execute sequencing, PC strobes, multiplier and go-switch stalls.
module pc_sequencer
  import picomips_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int OPCODE_WIDTH = OPCODE_WIDTH_DEF,
  parameter int INSTR_WIDTH  = INSTR_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [INSTR_WIDTH-1:0] instr,
  input  logic                   zero_flag,
  input  logic                   mul_done,
  input  logic                   go,
  output logic                   PC_incr,
  output logic                   PC_abs_branch,
  output logic                   PC_rel_branch,
  output logic [ADDR_WIDTH-1:0]  branch_addr,
  output logic                   reg_we,
  output logic                   mul_start,
  output logic                   halted
);

  seq_state_t state_q;
  seq_state_t state_d;

  logic [OPCODE_WIDTH-1:0] opcode;
  logic is_nop, is_alu, is_mul, is_beq, is_bne, is_jmp, is_wait, is_halt;

  assign opcode = instr[INSTR_WIDTH-1 -: OPCODE_WIDTH];

  // Bits between the opcode and the immediate belong to the datapath, not to sequencing.
  generate
    if (INSTR_WIDTH - OPCODE_WIDTH > ADDR_WIDTH) begin : g_mid_bits
      logic unused_mid_bits;
      assign unused_mid_bits = ^instr[INSTR_WIDTH-OPCODE_WIDTH-1:ADDR_WIDTH];
    end
  endgenerate

  op_decode #(
    .OPCODE_WIDTH(OPCODE_WIDTH)
  ) u_op_decode (
    .opcode (opcode),
    .is_nop (is_nop),
    .is_alu (is_alu),
    .is_mul (is_mul),
    .is_beq (is_beq),
    .is_bne (is_bne),
    .is_jmp (is_jmp),
    .is_wait(is_wait),
    .is_halt(is_halt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Strobes decode straight from the state register so an async reset clears them at once.
  always_comb begin
    state_d       = state_q;
    PC_incr       = 1'b0;
    PC_abs_branch = 1'b0;
    PC_rel_branch = 1'b0;
    reg_we        = 1'b0;
    mul_start     = 1'b0;
    case (state_q)
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_FETCH;
        if (is_alu) begin
          reg_we  = 1'b1;
          PC_incr = 1'b1;
        end else if (is_mul) begin
          mul_start = 1'b1;
          state_d   = S_MULW;
        end else if (is_beq) begin
          PC_rel_branch = zero_flag;
          PC_incr       = ~zero_flag;
        end else if (is_bne) begin
          PC_rel_branch = ~zero_flag;
          PC_incr       = zero_flag;
        end else if (is_jmp) begin
          PC_abs_branch = 1'b1;
        end else if (is_wait) begin
          state_d = S_WAITHI;
        end else if (is_halt) begin
          state_d = S_HALT;
        end else if (is_nop) begin
          PC_incr = 1'b1;
        end
      end
      S_MULW: begin
        if (mul_done) begin
          reg_we  = 1'b1;
          PC_incr = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_WAITHI: begin
        if (go) begin
          state_d = S_WAITLO;
        end
      end
      // Advance only on release so a held switch steps exactly one instruction.
      S_WAITLO: begin
        if (!go) begin
          PC_incr = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  assign halted      = (state_q == S_HALT);
  assign branch_addr = (state_q == S_EXEC) ? instr[ADDR_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench: synchronous ROM and PC models around the sequencer, instruction-level reference.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] rom_q;
  logic        zero_flag, mul_done, go;
  logic        PC_incr, PC_abs_branch, PC_rel_branch;
  logic [5:0]  branch_addr;
  logic        reg_we, mul_start, halted;

  logic [15:0] rom [64];
  logic [5:0]  pc;
  logic [11:0] outs;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [7:0] cycles;
    logic [5:0] pc;
    logic [3:0] n_incr;
    logic [3:0] n_abs;
    logic [3:0] n_rel;
    logic [3:0] n_multi;
    logic [3:0] n_we;
    logic [3:0] n_ms;
    logic [3:0] ba_err;
    logic [3:0] n_halted;
    logic [7:0] we_at;
  } res_t;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .instr        (rom_q),
    .zero_flag    (zero_flag),
    .mul_done     (mul_done),
    .go           (go),
    .PC_incr      (PC_incr),
    .PC_abs_branch(PC_abs_branch),
    .PC_rel_branch(PC_rel_branch),
    .branch_addr  (branch_addr),
    .reg_we       (reg_we),
    .mul_start    (mul_start),
    .halted       (halted)
  );

  assign outs = {PC_incr, PC_abs_branch, PC_rel_branch, branch_addr, reg_we, mul_start, halted};

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)          pc <= 6'd0;
    else if (PC_incr)      pc <= pc + 6'd1;
    else if (PC_abs_branch) pc <= branch_addr;
    else if (PC_rel_branch) pc <= pc + branch_addr;
  end

  always @(posedge clk) rom_q <= rom[pc];

  function automatic logic [15:0] mk(input int op, input logic [5:0] f);
    logic [2:0] o;
    o = op[2:0];
    return {o, 7'd0, f};
  endfunction

  // Expected outcome of one completed instruction, straight from the opcode rules.
  function automatic res_t predict(input logic [15:0] w, input logic zf, input int lat,
                                   input logic [5:0] pc0);
    res_t e;
    int   op;
    int   kind;
    e    = '0;
    op   = int'(w[15:13]);
    kind = 0;
    if (op == 3) kind = zf ? 2 : 0;
    if (op == 4) kind = zf ? 0 : 2;
    if (op == 5) kind = 1;
    e.cycles = (op == 2) ? 8'(2 + lat) : 8'd2;
    e.pc     = (kind == 0) ? pc0 + 6'd1 : (kind == 1) ? w[5:0] : pc0 + w[5:0];
    e.n_incr = {3'd0, kind == 0};
    e.n_abs  = {3'd0, kind == 1};
    e.n_rel  = {3'd0, kind == 2};
    e.n_we   = {3'd0, op == 1 || op == 2};
    e.n_ms   = {3'd0, op == 2};
    e.we_at  = (e.n_we != 0) ? e.cycles - 8'd1 : 8'hFF;
    return e;
  endfunction

  // Drives one instruction from its FETCH cycle to the cycle its PC strobe fires and records what happened.
  task automatic run_instr(input logic [15:0] w, input logic zf, input int lat, output res_t o);
    logic [2:0] s;
    o        = '0;
    o.we_at  = 8'hFF;
    o.cycles = 8'hFF;
    rom[pc]  = w;
    zero_flag = zf;
    for (int c = 0; c < 200; c++) begin
      if (c < 2) mul_done = (lat == 1 && c == 1) ? 1'b1 : 1'($urandom % 2);
      else       mul_done = (c == 1 + lat);
      go = 1'($urandom % 2);
      @(negedge clk);
      s = {PC_incr, PC_abs_branch, PC_rel_branch};
      if (s[2]) o.n_incr = o.n_incr + 4'd1;
      if (s[1]) o.n_abs  = o.n_abs + 4'd1;
      if (s[0]) o.n_rel  = o.n_rel + 4'd1;
      if ($countones(s) > 1) o.n_multi = o.n_multi + 4'd1;
      if (reg_we) begin
        o.n_we  = o.n_we + 4'd1;
        o.we_at = 8'(c);
      end
      if (mul_start) o.n_ms = o.n_ms + 4'd1;
      if (branch_addr !== ((c == 1) ? w[5:0] : 6'd0)) o.ba_err = o.ba_err + 4'd1;
      if (halted) o.n_halted = o.n_halted + 4'd1;
      @(posedge clk);
      #1;
      if (s != 3'b000) begin
        o.cycles = 8'(c + 1);
        break;
      end
    end
    o.pc     = pc;
    mul_done = 1'b0;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    zero_flag = 1'b0;
    mul_done  = 1'b0;
    go        = 1'b0;
    for (int i = 0; i < 64; i++) rom[i] = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (outs !== 12'd0 || pc !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got outs=%h pc=%0d want outs=000 pc=0", outs, pc);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_program();
    res_t o, e;
    logic [15:0] w;
    logic zf;
    rom[0] = mk(1, 6'd0);
    rom[1] = mk(0, 6'd0);
    rom[2] = mk(5, 6'd0);
    for (int i = 0; i < 5; i++) begin
      w  = rom[pc];
      zf = 1'($urandom % 2);
      e  = predict(w, zf, 1, pc);
      run_instr(w, zf, 1, o);
      n_vec++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL program[%0d] got %h want %h", i, o, e);
      end
    end
    n_vec++;
    if (pc !== 6'd2) begin
      n_fail++;
      $display("FAIL program_end_pc got %0d want 2", pc);
    end
  endtask

  task automatic test_branch();
    int          ops  [4] = '{3, 3, 4, 4};
    logic        zfs  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [5:0]  pcs  [4] = '{6'd2, 6'd5, 6'd2, 6'd5};
    res_t o, e;
    logic [15:0] w;
    for (int i = 0; i < 4; i++) begin
      w = mk(5, 6'd4);
      e = predict(w, 1'b0, 1, pc);
      run_instr(w, 1'b0, 1, o);
      n_vec++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL branch_jmp4[%0d] got %h want %h", i, o, e);
      end
      w = mk(ops[i], 6'b111110);
      e = predict(w, zfs[i], 1, pc);
      run_instr(w, zfs[i], 1, o);
      n_vec++;
      if (o !== e || o.pc !== pcs[i]) begin
        n_fail++;
        $display("FAIL branch[%0d] op=%0d zf=%0d got %h (pc %0d) want %h (pc %0d)",
                 i, ops[i], zfs[i], o, o.pc, e, pcs[i]);
      end
    end
  endtask

  task automatic test_mul();
    int   lats [2] = '{3, 1};
    logic [7:0] cyc [2] = '{8'd5, 8'd3};
    res_t o, e;
    logic [15:0] w;
    for (int i = 0; i < 2; i++) begin
      w = mk(2, 6'($urandom));
      e = predict(w, 1'b0, lats[i], pc);
      run_instr(w, 1'b0, lats[i], o);
      n_vec++;
      if (o !== e || o.cycles !== cyc[i]) begin
        n_fail++;
        $display("FAIL mul_lat%0d got %h want %h", lats[i], o, e);
      end
    end
  endtask

  task automatic test_random();
    res_t o, e;
    logic [15:0] w;
    logic zf;
    int lat;
    for (int i = 0; i < 40; i++) begin
      w   = mk($urandom_range(0, 5), 6'($urandom)) | {3'd0, 7'($urandom), 6'd0};
      zf  = 1'($urandom % 2);
      lat = $urandom_range(1, 4);
      e   = predict(w, zf, lat, pc);
      run_instr(w, zf, lat, o);
      n_vec++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL random[%0d] instr=%h zf=%0d lat=%0d got %h want %h", i, w, zf, lat, o, e);
      end
    end
  endtask

  task automatic test_wait();
    logic [5:0] pc0;
    int strobes;
    strobes = 0;
    pc0     = pc;
    rom[pc] = mk(6, 6'($urandom));
    for (int c = 0; c < 32; c++) begin
      go       = (c >= 12);
      mul_done = 1'($urandom % 2);
      @(negedge clk);
      strobes += $countones({PC_incr, PC_abs_branch, PC_rel_branch});
      @(posedge clk);
      #1;
      if (c == 11) begin
        n_vec++;
        if (pc !== pc0 || strobes != 0) begin
          n_fail++;
          $display("FAIL wait_go_low got pc=%0d strobes=%0d want pc=%0d strobes=0", pc, strobes, pc0);
        end
      end
    end
    n_vec++;
    if (pc !== pc0 || strobes != 0) begin
      n_fail++;
      $display("FAIL wait_go_held got pc=%0d strobes=%0d want pc=%0d strobes=0", pc, strobes, pc0);
    end
    go = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({PC_incr, PC_abs_branch, PC_rel_branch} !== 3'b100) begin
      n_fail++;
      $display("FAIL wait_release_strobe got %b want 100", {PC_incr, PC_abs_branch, PC_rel_branch});
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (pc !== pc0 + 6'd1) begin
      n_fail++;
      $display("FAIL wait_release_pc got %0d want %0d", pc, pc0 + 6'd1);
    end
  endtask

  task automatic test_halt();
    logic [5:0] pc0;
    int n_h, n_early, strobes;
    res_t o, e;
    n_h = 0; n_early = 0; strobes = 0;
    pc0 = pc;
    rom[pc] = mk(7, 6'($urandom));
    for (int c = 0; c < 52; c++) begin
      go       = 1'($urandom % 2);
      mul_done = 1'($urandom % 2);
      @(negedge clk);
      if (halted) begin
        if (c >= 2) n_h++;
        else        n_early++;
      end
      strobes += $countones({PC_incr, PC_abs_branch, PC_rel_branch, reg_we, mul_start});
      @(posedge clk);
      #1;
    end
    n_vec++;
    if (n_h != 50 || n_early != 0) begin
      n_fail++;
      $display("FAIL halt_flag got halted_cycles=%0d early=%0d want 50 and 0", n_h, n_early);
    end
    n_vec++;
    if (strobes != 0 || pc !== pc0) begin
      n_fail++;
      $display("FAIL halt_frozen got strobes=%0d pc=%0d want 0 and %0d", strobes, pc, pc0);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (outs !== 12'd0 || pc !== 6'd0) begin
      n_fail++;
      $display("FAIL halt_reset got outs=%h pc=%0d want 000 and 0", outs, pc);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    rom[0]  = mk(0, 6'd0);
    e = predict(rom[0], 1'b0, 1, pc);
    run_instr(rom[0], 1'b0, 1, o);
    n_vec++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL halt_restart got %h want %h", o, e);
    end
  endtask

  task automatic test_async_reset();
    logic [2:0] pre [3] = '{3'b001, 3'b110, 3'b110};
    res_t o, e;
    for (int s = 0; s < 3; s++) begin
      rom[pc]  = (s == 1) ? mk(1, 6'($urandom)) : mk(2, 6'($urandom));
      mul_done = 1'b0;
      go       = 1'b0;
      @(posedge clk);
      #1;
      if (s == 2) begin
        @(posedge clk);
        #1;
        mul_done = 1'b1;
      end
      #2;
      n_vec++;
      if ({PC_incr, reg_we, mul_start} !== pre[s]) begin
        n_fail++;
        $display("FAIL areset_pre[%0d] got %b want %b", s, {PC_incr, reg_we, mul_start}, pre[s]);
      end
      reset_n = 1'b0;
      #1;
      n_vec++;
      if (outs !== 12'd0) begin
        n_fail++;
        $display("FAIL areset_drop[%0d] got outs=%h want 000", s, outs);
      end
      @(posedge clk);
      #1;
      n_vec++;
      if (pc !== 6'd0 || outs !== 12'd0) begin
        n_fail++;
        $display("FAIL areset_hold[%0d] got pc=%0d outs=%h want 0 and 000", s, pc, outs);
      end
      mul_done = 1'b0;
      reset_n  = 1'b1;
    end
    rom[0] = mk(0, 6'd0);
    e = predict(rom[0], 1'b0, 1, pc);
    run_instr(rom[0], 1'b0, 1, o);
    n_vec++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL areset_restart got %h want %h", o, e);
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_branch();
    test_mul();
    test_random();
    test_wait();
    test_halt();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multi-cycle control FSM for picoMIPS. It drives the program counter's control strobes and branch operand, and sequences each instruction through fetch and execute. It also stalls on the multiplier handshake and on the external "go" switch. It sits between the synchronous instruction ROM (addressed by the PC) and the PC, register file and multiplier.

Parameters:
ADDR_WIDTH, 6, program address width; must match the PC and ROM.
OPCODE_WIDTH, 3, opcode field width (instr[INSTR_WIDTH-1 -: OPCODE_WIDTH]).
INSTR_WIDTH, 16, instruction word width; the low ADDR_WIDTH bits are the immediate/branch field.

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
instr  in  INSTR_WIDTH  ROM output; valid in EXEC (ROM has 1-cycle synchronous read).
zero_flag  in  1  registered ALU zero flag from the previous ALU/MUL op.
mul_done  in  1  multiplier result-ready pulse/level.
go  in  1  external synchronised, debounced continue switch.
PC_incr  out  1  PC +1 strobe.
PC_abs_branch  out  1  PC load strobe.
PC_rel_branch  out  1  PC add-offset strobe.
branch_addr  out  ADDR_WIDTH  absolute target or two's-complement offset (instr[ADDR_WIDTH-1:0]).
reg_we  out  1  register file write enable.
mul_start  out  1  multiplier start pulse.
halted  out  1  high in HALT.

Behaviour:
- Opcodes: NOP=0, ALU=1, MUL=2, BEQ=3, BNE=4, JMP=5, WAIT=6, HALT=7.
- States: FETCH, EXEC, MULW, WAITHI, WAITLO, HALT. Reset state is FETCH.
- Reset values: all outputs 0. Async reset_n low mid-instruction forces FETCH immediately and drops every strobe, including mul_start; no partial PC update.
- FETCH (1 cycle): all strobes 0; next state EXEC.
- EXEC transitions:
  - NOP, or any opcode not listed: PC_incr=1 -> FETCH.
  - ALU: reg_we=1, PC_incr=1 -> FETCH.
  - MUL: mul_start=1 (1-cycle pulse) -> MULW.
  - BEQ: PC_rel_branch=1 if zero_flag=1, else PC_incr=1 -> FETCH.
  - BNE: same as BEQ with the condition inverted.
  - JMP: PC_abs_branch=1 -> FETCH.
  - WAIT: -> WAITHI, no strobe.
  - HALT: -> HALT, no strobe.
- MULW: hold until mul_done=1. In that cycle reg_we=1 and PC_incr=1 -> FETCH. If mul_done is already 1 on the first MULW cycle, complete in that cycle.
- WAITHI: stay while go=0; go=1 -> WAITLO. WAITLO: stay while go=1; go=0 -> PC_incr=1 -> FETCH. A held switch advances exactly one instruction.
- HALT: halted=1, all strobes 0; exit only via reset_n.
- Strobes are combinational from state + opcode and asserted only in the last cycle of an instruction. The PC updates on the edge leaving that cycle.
- At most one of PC_incr, PC_abs_branch, PC_rel_branch is high in any cycle, and exactly one fires per completed instruction (except HALT).
- Latency: 2 cycles per NOP/ALU/branch/JMP; 2+N for MUL, where N is the cycles until mul_done; WAIT depends on go.
- branch_addr = instr[ADDR_WIDTH-1:0] whenever state=EXEC, else 0. Relative offset range is -2^(ADDR_WIDTH-1) .. 2^(ADDR_WIDTH-1)-1. Wrap-around is modulo 2^ADDR_WIDTH and handled by the PC adder.
- go and mul_done are ignored outside their wait states.

Decomposition:
- picomips_pkg: opcode_t enum, seq_state_t enum, OPCODE_WIDTH/INSTR_WIDTH/ADDR_WIDTH defaults, opcode field slice function.
- Sub-module op_decode: combinational opcode -> one-hot class (is_alu, is_mul, is_beq, ...), with unknown -> NOP. The FSM stays in pc_sequencer.

Test Plan:
- Reset, then ROM = {ALU, NOP, JMP 0} -> PC sequence 0,1,2,0,1; reg_we high exactly once per ALU EXEC; 2 cycles per instruction.
- BEQ offset 6'b111110 (-2) at addr 4: zero_flag=1 -> PC_rel_branch, PC=2; zero_flag=0 -> PC_incr, PC=5. BNE is the mirror case.
- MUL with mul_done after 3 MULW cycles -> mul_start 1-cycle pulse, reg_we+PC_incr on the done cycle, 5 cycles total. Also mul_done already high -> completes in the first MULW cycle (3 cycles).
- WAIT: go held 0 for 10 cycles -> PC frozen; go=1 for 20 cycles -> still frozen; go=0 -> single PC_incr.
- HALT -> halted=1 and PC frozen for 50 cycles; reset_n pulse -> FETCH, PC=0.
- reset_n asserted asynchronously mid-MULW and mid-EXEC (between clock edges) -> outputs 0 immediately, no PC strobe; one-hot-strobe assertion checked every cycle.
